// File: rtl/mux_stream_param_module.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// Channels are picked by direct select or by round-robin arbitration among valid inputs.
module mux_stream_param_module #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 mode_i,
    input  logic [SEL_W-1:0]     sel_i,
    input  logic [N*WIDTH-1:0]   in_data_i,
    input  logic [N-1:0]         in_valid_i,
    output logic [N-1:0]         in_ready_o,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [SEL_W-1:0]     out_ch_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W:0]   scan_sum;
    logic [SEL_W-1:0] scan_idx;
    logic             found;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] ch_data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_data[i] = in_data_i[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin scans ptr, ptr+1, ... modulo N and grants the first valid channel.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        if (!mode_i) begin
            if ({1'b0, sel_i} < (SEL_W+1)'(N)) begin
                grant[sel_i] = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (scan_sum >= (SEL_W+1)'(N)) begin
                    scan_sum = scan_sum - (SEL_W+1)'(N);
                end
                scan_idx = scan_sum[SEL_W-1:0];
                if (!found && in_valid_i[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = SEL_W'(i);
            end
        end
    end

    assign load       = ~out_valid_q | out_ready_i;
    assign in_ready_o = grant & {N{load & rst_n_i}};
    assign xfer       = |(in_valid_i & in_ready_o);

    // A push replaces the register even while it is being popped, so no bubble appears.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = ch_data[grant_idx];
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode_i) begin
                ptr_d = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

endmodule
